// File: rtl/seq_multiplier.sv
// seq_multiplier: n-bit sequential shift-add / radix-2 Booth multiplier with start/ready/done handshake
module seq_multiplier #(
    parameter int n = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [n-1:0]   multiplicand,
    input  logic [n-1:0]   multiplier,
    output logic [2*n-1:0] product,
    output logic           ready,
    output logic           done,
    output logic           init,
    output logic           add_shift,
    output logic           shift
);
    localparam int CW = $clog2(n + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]    state;
    logic [n-1:0]  a, q, m;
    logic          q_1, mode, op, sub;
    logic [CW-1:0] count;
    logic [n:0]    ea, em, sum;
    // one extra bit holds the unsigned carry or the Booth sign so M = -2^(n-1) cannot overflow
    always_comb begin
        ea  = {mode & a[n-1], a};
        em  = {mode & m[n-1], m};
        op  = mode ? q[0] ^ q_1 : q[0];
        sub = mode & q[0] & ~q_1;
        sum = !op ? ea : sub ? ea - em : ea + em;
    end
    assign ready     = state == IDLE;
    assign done      = state == DONE;
    assign init      = ready & start & ~reset;
    assign add_shift = state == RUN & op;
    assign shift     = state == RUN & ~op;
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            a       <= '0;
            q       <= '0;
            m       <= '0;
            q_1     <= 1'b0;
            mode    <= 1'b0;
            count   <= '0;
            product <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                m     <= multiplicand;
                q     <= multiplier;
                mode  <= signed_mode;
                a     <= '0;
                q_1   <= 1'b0;
                count <= CW'(n);
                state <= RUN;
            end
        end else if (state == RUN) begin
            a     <= sum[n:1];
            q     <= {sum[0], q[n-1:1]};
            q_1   <= q[0];
            count <= count - CW'(1);
            if (count == CW'(1)) begin
                state   <= DONE;
                product <= {sum[n:1], sum[0], q[n-1:1]};
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule
